// File: rtl/riscv_v_dispatch.sv
// Integer-side dispatcher for the vector unit: instruction FIFO, v2i rd tag FIFO and integer-register busy scoreboard.
// Optional same-cycle bypass of an empty FIFO is enabled by defining RISCV_V_DISPATCH_BYPASS_EN.
module riscv_v_dispatch #(
  parameter int IQ_DEPTH   = 4,
  parameter int PEND_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_pipe,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic [31:0] core_instr,
  input  logic [31:0] core_rs1_data,
  input  logic [4:0]  core_rs_a,
  input  logic [4:0]  core_rs_b,
  output logic        core_raw_stall,
  output logic [31:0] instruction_id,
  output logic [31:0] int_rf_rd_data_id,
  input  logic        riscv_v_stall,
  input  logic        int_rf_wr_en_wb,
  input  logic [31:0] int_rf_wr_data_wb,
  output logic        irf_wr_en,
  output logic [4:0]  irf_wr_addr,
  output logic [31:0] irf_wr_data,
  output logic        pend_full
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int IAW = $clog2(IQ_DEPTH);
  localparam int PAW = $clog2(PEND_DEPTH);
  localparam int CW  = $clog2(PEND_DEPTH + 1);
  localparam logic [IAW:0]  IQ_ONE  = {{IAW{1'b0}}, 1'b1};
  localparam logic [PAW:0]  TAG_ONE = {{PAW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [31:0]   iq_instr [IQ_DEPTH];
  logic [31:0]   iq_data  [IQ_DEPTH];
  logic [IAW:0]  iq_wr, iq_rd;
  logic          iq_empty, iq_full;
  logic [4:0]    tag_mem [PEND_DEPTH];
  logic [PAW:0]  tag_wr, tag_rd;
  logic          tag_empty;
  logic [CW-1:0] busy_cnt [32];
  logic [31:0]   busy;

  logic [31:0] cand_instr, cand_data;
  logic        cand_valid, cand_bypass, cand_v2i;
  logic        present, pop, iq_pop, push, issue, retire;
  logic [4:0]  issue_rd, retire_rd;

  function automatic logic is_v2i(input logic [31:0] w);
    return (w[6:0] == 7'b1010111) && (w[14:12] == 3'b010) && (w[31:26] == 6'b010000) &&
           (w[19:15] == 5'd0) && (w[11:7] != 5'd0);
  endfunction

  assign iq_empty   = (iq_wr == iq_rd);
  assign iq_full    = (iq_wr[IAW] != iq_rd[IAW]) && (iq_wr[IAW-1:0] == iq_rd[IAW-1:0]);
  assign tag_empty  = (tag_wr == tag_rd);
  assign pend_full  = (tag_wr[PAW] != tag_rd[PAW]) && (tag_wr[PAW-1:0] == tag_rd[PAW-1:0]);
  assign core_ready = !iq_full;
  assign issue_rd   = cand_instr[11:7];
  assign retire     = int_rf_wr_en_wb && !tag_empty;
  assign retire_rd  = tag_mem[tag_rd[PAW-1:0]];

  // A v2i head waits while every tag slot is taken; decode sees a NOP meanwhile.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    cand_instr  = iq_instr[iq_rd[IAW-1:0]];
    cand_data   = iq_data[iq_rd[IAW-1:0]];
    cand_valid  = !iq_empty;
    cand_bypass = 1'b0;
`ifdef RISCV_V_DISPATCH_BYPASS_EN
    if (iq_empty && core_valid && !riscv_v_stall && !clear_pipe) begin
      cand_instr  = core_instr;
      cand_data   = core_rs1_data;
      cand_valid  = 1'b1;
      cand_bypass = 1'b1;
    end
`endif
    cand_v2i          = is_v2i(cand_instr);
    present           = cand_valid && !(cand_v2i && pend_full);
    instruction_id    = present ? cand_instr : NOP;
    int_rf_rd_data_id = present ? cand_data : 32'd0;
    pop               = present && !riscv_v_stall;
    iq_pop            = pop && !cand_bypass;
    issue             = pop && cand_v2i;
    push              = core_valid && core_ready && !clear_pipe && !(cand_bypass && present);
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < 32; r++) busy[r] = (busy_cnt[r] != '0);
    core_raw_stall = busy[core_rs_a] || busy[core_rs_b];
  end

  // NOTE: FIFO storage carries no reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      iq_instr[iq_wr[IAW-1:0]] <= core_instr;
      iq_data[iq_wr[IAW-1:0]]  <= core_rs1_data;
    end
    if (issue) tag_mem[tag_wr[PAW-1:0]] <= issue_rd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iq_wr <= '0;
      iq_rd <= '0;
    end else if (clear_pipe) begin
      iq_rd <= iq_wr;
    end else begin
      if (push)   iq_wr <= iq_wr + IQ_ONE;
      if (iq_pop) iq_rd <= iq_rd + IQ_ONE;
    end
  end

  // Issued tags survive clear_pipe: the vector unit will still write those results back.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr      <= '0;
      tag_rd      <= '0;
      irf_wr_en   <= 1'b0;
      irf_wr_addr <= 5'd0;
      irf_wr_data <= 32'd0;
      for (int r = 0; r < 32; r++) busy_cnt[r] <= '0;
    end else begin
      if (issue)  tag_wr <= tag_wr + TAG_ONE;
      if (retire) begin
        tag_rd      <= tag_rd + TAG_ONE;
        irf_wr_addr <= retire_rd;
        irf_wr_data <= int_rf_wr_data_wb;
      end
      irf_wr_en <= retire;
      for (int r = 0; r < 32; r++) begin
        if (issue && issue_rd == 5'(r) && !(retire && retire_rd == 5'(r)))
          busy_cnt[r] <= busy_cnt[r] + CNT_ONE;
        else if (retire && retire_rd == 5'(r) && !(issue && issue_rd == 5'(r)))
          busy_cnt[r] <= busy_cnt[r] - CNT_ONE;
      end
    end
  end

  // A writeback with no outstanding tag is a vector-unit protocol error; it is dropped.
  always_ff @(posedge clk) begin
    if (!rst && int_rf_wr_en_wb) assert (!tag_empty);
  end

endmodule

// File: tb/tb_riscv_v_dispatch.sv
// Self-checking bench for riscv_v_dispatch: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_riscv_v_dispatch;

  localparam int IQD = 4;
  localparam int PD  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear_pipe = 1'b0, core_valid = 1'b0, riscv_v_stall = 1'b0, int_rf_wr_en_wb = 1'b0;
  logic [31:0] core_instr = '0, core_rs1_data = '0, int_rf_wr_data_wb = '0;
  logic [4:0]  core_rs_a = '0, core_rs_b = '0;
  logic        core_ready, core_raw_stall, irf_wr_en, pend_full;
  logic [31:0] instruction_id, int_rf_rd_data_id, irf_wr_data;
  logic [4:0]  irf_wr_addr;

  always #5 clk = ~clk;

  riscv_v_dispatch #(.IQ_DEPTH(IQD), .PEND_DEPTH(PD)) dut (
    .clk(clk), .rst(rst), .clear_pipe(clear_pipe), .core_valid(core_valid), .core_ready(core_ready),
    .core_instr(core_instr), .core_rs1_data(core_rs1_data), .core_rs_a(core_rs_a), .core_rs_b(core_rs_b),
    .core_raw_stall(core_raw_stall), .instruction_id(instruction_id), .int_rf_rd_data_id(int_rf_rd_data_id),
    .riscv_v_stall(riscv_v_stall), .int_rf_wr_en_wb(int_rf_wr_en_wb), .int_rf_wr_data_wb(int_rf_wr_data_wb),
    .irf_wr_en(irf_wr_en), .irf_wr_addr(irf_wr_addr), .irf_wr_data(irf_wr_data), .pend_full(pend_full)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain queues of buffered instructions and outstanding rd tags.
  typedef struct { logic [31:0] instr; logic [31:0] data; } entry_t;
  entry_t      m_iq[$];
  logic [4:0]  m_tags[$];
  logic        m_wr_en   = 1'b0;
  logic [4:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;

  logic        s_valid = 0, s_stall = 0, s_wb = 0, s_clear = 0;
  logic [31:0] s_instr = '0, s_data = '0, s_wbd = '0;
  logic [4:0]  s_rs_a = '0, s_rs_b = '0;

  function automatic bit m_v2i(input logic [31:0] w);
    return w[6:0] == 7'b1010111 && w[14:12] == 3'b010 && w[31:26] == 6'b010000 &&
           w[19:15] == 5'd0 && w[11:7] != 5'd0;
  endfunction

  function automatic bit m_busy(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (m_tags[i]) if (m_tags[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] alu(input int k);
    return {6'b000000, 1'b1, 5'(k), 5'(k + 1), 3'b000, 5'(k + 2), 7'b1010111};
  endfunction

  function automatic logic [31:0] vmvxs(input logic [4:0] rd);
    return {6'b010000, 1'b1, 5'd3, 5'd0, 3'b010, rd, 7'b1010111};
  endfunction

  // One clock: apply staged inputs at the falling edge, compare, then advance the model.
  task automatic tick();
    bit          head_ok, pop, issue, push;
    logic [31:0] exp_id, exp_data;
    @(negedge clk);
    core_valid = s_valid; core_instr = s_instr; core_rs1_data = s_data;
    riscv_v_stall = s_stall; int_rf_wr_en_wb = s_wb; int_rf_wr_data_wb = s_wbd;
    clear_pipe = s_clear; core_rs_a = s_rs_a; core_rs_b = s_rs_b;
    #1;
    head_ok  = m_iq.size() > 0 && !(m_v2i(m_iq[0].instr) && m_tags.size() == PD);
    exp_id   = head_ok ? m_iq[0].instr : NOP;
    exp_data = head_ok ? m_iq[0].data : 32'd0;
    check("instruction_id", instruction_id, exp_id);
    check("int_rf_rd_data_id", int_rf_rd_data_id, exp_data);
    check("core_ready", 32'(core_ready), 32'(m_iq.size() < IQD));
    check("pend_full", 32'(pend_full), 32'(m_tags.size() == PD));
    check("core_raw_stall", 32'(core_raw_stall), 32'(m_busy(s_rs_a) || m_busy(s_rs_b)));
    check("irf_wr_en", 32'(irf_wr_en), 32'(m_wr_en));
    check("irf_wr_addr", 32'(irf_wr_addr), 32'(m_wr_addr));
    check("irf_wr_data", irf_wr_data, m_wr_data);
    pop   = head_ok && !s_stall;
    issue = pop && m_v2i(m_iq[0].instr);
    push  = s_valid && m_iq.size() < IQD && !s_clear;
    if (s_wb && m_tags.size() > 0) begin
      m_wr_en   = 1'b1;
      m_wr_addr = m_tags.pop_front();
      m_wr_data = s_wbd;
    end else begin
      m_wr_en = 1'b0;
    end
    if (issue) m_tags.push_back(m_iq[0].instr[11:7]);
    if (s_clear) m_iq.delete();
    else begin
      if (pop)  void'(m_iq.pop_front());
      if (push) m_iq.push_back('{instr: s_instr, data: s_data});
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input bit st, input bit wb,
                     input logic [31:0] wbd, input bit clr);
    s_valid = v; s_instr = ins; s_data = $urandom(); s_stall = st;
    s_wb = wb; s_wbd = wbd; s_clear = clr;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 32'd0, 0, 0, 32'd0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset core_ready", 32'(core_ready), 32'd1);
    check("reset instruction_id", instruction_id, NOP);
    check("reset int_rf_rd_data_id", int_rf_rd_data_id, 32'd0);
    check("reset core_raw_stall", 32'(core_raw_stall), 32'd0);
    check("reset irf_wr_en", 32'(irf_wr_en), 32'd0);
    check("reset irf_wr_addr", 32'(irf_wr_addr), 32'd0);
    check("reset irf_wr_data", irf_wr_data, 32'd0);
    check("reset pend_full", 32'(pend_full), 32'd0);

    // Four ALU ops stream out in order one cycle after each push, then NOP.
    for (int k = 0; k < 7; k++) begin
      if (k < 4) cyc(1, alu(k), 0, 0, 32'd0, 0);
      else       idle(1);
      if (k >= 1 && k <= 4) check("stream order", instruction_id, alu(k - 1));
      if (k == 5)           check("stream ends NOP", instruction_id, NOP);
    end

    // Fill under stall, then release.
    for (int k = 0; k < 4; k++) cyc(1, alu(10 + k), 1, 0, 32'd0, 0);
    cyc(0, 32'd0, 1, 0, 32'd0, 0);
    check("full core_ready", 32'(core_ready), 32'd0);
    check("full head", instruction_id, alu(10));
    cyc(0, 32'd0, 0, 0, 32'd0, 0);
    cyc(0, 32'd0, 0, 0, 32'd0, 0);
    check("ready after pop", 32'(core_ready), 32'd1);
    check("second head", instruction_id, alu(11));
    idle(4);

    // vmv.x.s x5 then writeback.
    s_rs_a = 5'd5;
    cyc(1, vmvxs(5'd5), 0, 0, 32'd0, 0);
    idle(1);
    idle(1);
    check("x5 raw stall", 32'(core_raw_stall), 32'd1);
    cyc(0, 32'd0, 0, 1, 32'hDEAD_BEEF, 0);
    idle(1);
    check("x5 wr_en", 32'(irf_wr_en), 32'd1);
    check("x5 wr_addr", 32'(irf_wr_addr), 32'd5);
    check("x5 wr_data", irf_wr_data, 32'hDEAD_BEEF);
    check("x5 stall drops", 32'(core_raw_stall), 32'd0);
    s_rs_a = 5'd0;

    // Five v2i ops against four tag slots.
    for (int k = 1; k <= 5; k++) cyc(1, vmvxs(5'(k)), 0, 0, 32'd0, 0);
    idle(2);
    check("tags full", 32'(pend_full), 32'd1);
    check("fifth held as NOP", instruction_id, NOP);
    cyc(0, 32'd0, 0, 1, 32'h0000_0101, 0);
    idle(1);
    check("slot freed", 32'(pend_full), 32'd0);
    check("fifth presented", instruction_id, vmvxs(5'd5));
    idle(1);
    check("tags full again", 32'(pend_full), 32'd1);
    for (int k = 0; k < 4; k++) cyc(0, 32'd0, 0, 1, 32'h0000_0200 + 32'(k), 0);
    idle(1);
    check("last retire addr", 32'(irf_wr_addr), 32'd5);

    // Two tags for x7.
    s_rs_a = 5'd7;
    cyc(1, vmvxs(5'd7), 0, 0, 32'd0, 0);
    cyc(1, vmvxs(5'd7), 0, 0, 32'd0, 0);
    idle(2);
    check("x7 busy", 32'(core_raw_stall), 32'd1);
    cyc(0, 32'd0, 0, 1, 32'h7777_0001, 0);
    idle(1);
    check("x7 still busy", 32'(core_raw_stall), 32'd1);
    cyc(0, 32'd0, 0, 1, 32'h7777_0002, 0);
    idle(1);
    check("x7 free", 32'(core_raw_stall), 32'd0);

    // Flush with three queued and one tag outstanding.
    s_rs_a = 5'd9;
    cyc(1, vmvxs(5'd9), 0, 0, 32'd0, 0);
    idle(1);
    for (int k = 0; k < 3; k++) cyc(1, alu(20 + k), 1, 0, 32'd0, 0);
    cyc(1, alu(30), 1, 0, 32'd0, 1);
    idle(1);
    check("flush NOP", instruction_id, NOP);
    check("flush ready", 32'(core_ready), 32'd1);
    check("x9 survives flush", 32'(core_raw_stall), 32'd1);
    cyc(0, 32'd0, 0, 1, 32'h1234_5678, 0);
    idle(1);
    check("x9 wr_addr", 32'(irf_wr_addr), 32'd9);
    check("x9 wr_data", irf_wr_data, 32'h1234_5678);
    s_rs_a = 5'd0;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4)      ins = alu($urandom_range(0, 31));
      else if (sel < 7) ins = vmvxs(5'($urandom_range(0, 7)));
      else if (sel < 8) ins = vmvxs(5'($urandom_range(1, 7))) | 32'h0000_8000;
      else              ins = $urandom();
      s_rs_a = 5'($urandom_range(0, 7));
      s_rs_b = 5'($urandom_range(0, 7));
      cyc(($urandom() % 10) < 6, ins, ($urandom() % 4) == 0,
          m_tags.size() > 0 && ($urandom() % 3) == 0, $urandom(), ($urandom() % 40) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
